// File: rtl/flag_branch_unit_if.sv
// EX-stage flag inputs, branch req/ack handshake and flag/branch results of flag_branch_unit.
// master drives EX and branch requests; slave is the flag/branch unit.
`timescale 1ns/1ps
interface flag_branch_unit_if #(
    parameter int HOLD_CNT_W = 8
);
    logic                  ex_valid;
    logic                  ex_stall;
    logic [3:0]            aluop;
    logic                  Z;
    logic                  N;
    logic                  V;
    logic                  br_req;
    logic [2:0]            br_ccc;
    logic                  flush;
    logic                  flag_Z;
    logic                  flag_N;
    logic                  flag_V;
    logic                  br_ack;
    logic                  br_taken;
    logic [HOLD_CNT_W-1:0] hold_cnt;

    modport master (
        output ex_valid, ex_stall, aluop, Z, N, V, br_req, br_ccc, flush,
        input  flag_Z, flag_N, flag_V, br_ack, br_taken, hold_cnt
    );

    modport slave (
        input  ex_valid, ex_stall, aluop, Z, N, V, br_req, br_ccc, flush,
        output flag_Z, flag_N, flag_V, br_ack, br_taken, hold_cnt
    );
endinterface

// File: rtl/flag_branch_unit.sv
// Architectural Z/N/V flags with conditional-branch resolution; ack is combinational, flags land 1 cycle after commit.
// Branches wait in HOLD while a flag writer sits in EX; FLAG_FWD_EN resolves against an unstalled writer's ALU flags.
`timescale 1ns/1ps
module flag_branch_unit #(
    parameter int HOLD_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    flag_branch_unit_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;
    localparam logic [2:0] CCC_UNCOND = 3'b111;

    state_t                state;
    state_t                state_nxt;
    logic [2:0]            upd_mask;   // bit order {Z,N,V}
    logic [2:0]            alu_flags;
    logic [2:0]            flags_q;
    logic                  fw;
    logic                  commit;
    logic                  ack;
    logic                  taken;
    logic [HOLD_CNT_W-1:0] hold_q;

    function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] f);
        logic z;
        logic n;
        logic v;
        {z, n, v} = f;
        case (ccc)
            3'b000:  cond_met = !z;
            3'b001:  cond_met = z;
            3'b010:  cond_met = !z && !n;
            3'b011:  cond_met = n;
            3'b100:  cond_met = z || !n;
            3'b101:  cond_met = z || n;
            3'b110:  cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

    always_comb begin
        case (bus.aluop)
            4'b0000, 4'b0001:                   upd_mask = 3'b111;
            4'b0010, 4'b0100, 4'b0101, 4'b0110: upd_mask = 3'b100;
            default:                            upd_mask = 3'b000;
        endcase
    end

    assign alu_flags = {bus.Z, bus.N, bus.V};
    // A stalled writer still blocks branches: its flags will land once it unstalls.
    assign fw        = bus.ex_valid && (upd_mask != 3'b000);
    assign commit    = bus.ex_valid && !bus.ex_stall;

`ifdef FLAG_FWD_EN
    logic [2:0] fwd_flags;
    assign fwd_flags = (alu_flags & upd_mask) | (flags_q & ~upd_mask);
`endif

    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        taken     = 1'b0;
        if (rst || bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.br_req) begin
                        if (!fw || bus.br_ccc == CCC_UNCOND) begin
                            ack   = 1'b1;
                            taken = cond_met(bus.br_ccc, flags_q);
                        end
`ifdef FLAG_FWD_EN
                        else if (!bus.ex_stall) begin
                            ack   = 1'b1;
                            taken = cond_met(bus.br_ccc, fwd_flags);
                        end
`endif
                        else begin
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.br_req) begin
                        state_nxt = IDLE;
                    end else if (!fw) begin
                        ack       = 1'b1;
                        taken     = cond_met(bus.br_ccc, flags_q);
                        state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            flags_q <= 3'b000;
            hold_q  <= '0;
        end else begin
            state <= state_nxt;
            if (commit) begin
                flags_q <= (alu_flags & upd_mask) | (flags_q & ~upd_mask);
            end
            // Counts the cycle that enters HOLD as well as every cycle that stays there.
            if (state_nxt == HOLD && hold_q != '1) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign bus.flag_Z   = flags_q[2];
    assign bus.flag_N   = flags_q[1];
    assign bus.flag_V   = flags_q[0];
    assign bus.br_ack   = ack;
    assign bus.br_taken = taken;
    assign bus.hold_cnt = hold_q;
endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed and randomized bench for flag_branch_unit; a second instance with a 2-bit hold counter tracks saturation.
`timescale 1ns/1ps
module tb_flag_branch_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    flag_branch_unit_if #(.HOLD_CNT_W(8)) bus ();
    flag_branch_unit_if #(.HOLD_CNT_W(2)) bus2 ();

    flag_branch_unit #(.HOLD_CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
    flag_branch_unit #(.HOLD_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus2.ex_valid = bus.ex_valid;
    assign bus2.ex_stall = bus.ex_stall;
    assign bus2.aluop    = bus.aluop;
    assign bus2.Z        = bus.Z;
    assign bus2.N        = bus.N;
    assign bus2.V        = bus.V;
    assign bus2.br_req   = bus.br_req;
    assign bus2.br_ccc   = bus.br_ccc;
    assign bus2.flush    = bus.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural flags {Z,N,V}, whether a branch is still waiting, hold counters.
    bit [2:0] m_flags;
    bit       m_pend;
    int       m_hold;
    int       m_hold2;
    bit       e_ack;
    bit       e_taken;

    function automatic bit [2:0] mask_of(input logic [3:0] op);
        case (op)
            4'd0, 4'd1:             return 3'b111;
            4'd2, 4'd4, 4'd5, 4'd6: return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    function automatic bit cond_true(input logic [2:0] ccc, input bit [2:0] f);
        case (ccc)
            3'd0:    return f[2] == 0;
            3'd1:    return f[2] == 1;
            3'd2:    return f[2] == 0 && f[1] == 0;
            3'd3:    return f[1] == 1;
            3'd4:    return f[2] == 1 || f[1] == 0;
            3'd5:    return f[2] == 1 || f[1] == 1;
            3'd6:    return f[0] == 1;
            default: return 1;
        endcase
    endfunction

    function automatic void predict();
        bit [2:0] m;
        bit [2:0] alu;
        m       = bus.ex_valid ? mask_of(bus.aluop) : 3'b000;
        alu     = {bus.Z, bus.N, bus.V};
        e_ack   = 0;
        e_taken = 0;
        if (rst || bus.flush || !bus.br_req) return;
        if (!m_pend && (bus.br_ccc == 3'd7 || m == 0)) begin
            e_ack = 1; e_taken = cond_true(bus.br_ccc, m_flags);
        end else if (m_pend && m == 0) begin
            e_ack = 1; e_taken = cond_true(bus.br_ccc, m_flags);
        end
`ifdef FLAG_FWD_EN
        else if (!m_pend && !bus.ex_stall) begin
            e_ack = 1; e_taken = cond_true(bus.br_ccc, (alu & m) | (m_flags & ~m));
        end
`endif
    endfunction

    function automatic void advance();
        bit [2:0] m;
        bit [2:0] alu;
        bit       waiting;
        m       = bus.ex_valid ? mask_of(bus.aluop) : 3'b000;
        alu     = {bus.Z, bus.N, bus.V};
        waiting = !rst && !bus.flush && bus.br_req && !e_ack;
        if (rst) begin
            m_flags = 0; m_hold = 0; m_hold2 = 0;
        end else begin
            if (bus.ex_valid && !bus.ex_stall) m_flags = (alu & m) | (m_flags & ~m);
            if (waiting) begin
                if (m_hold < 255) m_hold++;
                if (m_hold2 < 3) m_hold2++;
            end
        end
        m_pend = waiting;
    endfunction

    task automatic apply(input logic r, input logic vld, input logic stl, input logic [3:0] op,
                         input logic [2:0] znv, input logic req, input logic [2:0] ccc, input logic fl);
        @(negedge clk);
        rst = r; bus.ex_valid = vld; bus.ex_stall = stl; bus.aluop = op;
        {bus.Z, bus.N, bus.V} = znv;
        bus.br_req = req; bus.br_ccc = ccc; bus.flush = fl;
        #2;
        predict();
    endtask

    task automatic edge_step();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 4'd0, 3'b000, 1, 3'd7, 0);
        n_checks++;
        if (bus.br_ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", bus.br_ack); else n_pass++;
        edge_step();
        apply(1, 0, 0, 4'd0, 3'b000, 0, 3'd0, 0);
        edge_step();
        n_checks++;
        if ({bus.flag_Z, bus.flag_N, bus.flag_V} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {bus.flag_Z, bus.flag_N, bus.flag_V}); else n_pass++;
        n_checks++;
        if (bus.hold_cnt !== 8'd0) $display("FAIL reset_hold got=%0d exp=0", bus.hold_cnt); else n_pass++;
        apply(0, 0, 0, 4'd0, 3'b000, 1, 3'd1, 0);
        n_checks++;
        if ({bus.br_ack, bus.br_taken} !== 2'b10)
            $display("FAIL reset_eq_branch ack/taken got=%b exp=10", {bus.br_ack, bus.br_taken}); else n_pass++;
        edge_step();
    endtask

    task automatic test_flag_mask();
        apply(0, 1, 0, 4'd0, 3'b101, 0, 3'd0, 0);
        edge_step();
        n_checks++;
        if ({bus.flag_Z, bus.flag_N, bus.flag_V} !== 3'b101)
            $display("FAIL mask_add got=%b exp=101", {bus.flag_Z, bus.flag_N, bus.flag_V}); else n_pass++;
        apply(0, 1, 0, 4'd2, 3'b010, 0, 3'd0, 0);
        n_checks++;
        if (bus.flag_Z !== 1'b1) $display("FAIL mask_latency got=%b exp=1", bus.flag_Z); else n_pass++;
        edge_step();
        n_checks++;
        if ({bus.flag_Z, bus.flag_N, bus.flag_V} !== 3'b001)
            $display("FAIL mask_xor got=%b exp=001", {bus.flag_Z, bus.flag_N, bus.flag_V}); else n_pass++;
        apply(0, 1, 0, 4'd3, 3'b111, 0, 3'd0, 0);
        edge_step();
        n_checks++;
        if ({bus.flag_Z, bus.flag_N, bus.flag_V} !== 3'b001)
            $display("FAIL mask_none got=%b exp=001", {bus.flag_Z, bus.flag_N, bus.flag_V}); else n_pass++;
    endtask

    task automatic test_fw_branch();
        apply(0, 1, 0, 4'd1, 3'b100, 1, 3'd1, 0);
`ifdef FLAG_FWD_EN
        n_checks++;
        if ({bus.br_ack, bus.br_taken} !== 2'b11)
            $display("FAIL fw_fwd ack/taken got=%b exp=11", {bus.br_ack, bus.br_taken}); else n_pass++;
        edge_step();
        n_checks++;
        if (bus.hold_cnt !== 8'd0) $display("FAIL fw_fwd_hold got=%0d exp=0", bus.hold_cnt); else n_pass++;
`else
        n_checks++;
        if (bus.br_ack !== 1'b0) $display("FAIL fw_hold_ack got=%b exp=0", bus.br_ack); else n_pass++;
        edge_step();
        apply(0, 0, 0, 4'd0, 3'b000, 1, 3'd1, 0);
        n_checks++;
        if ({bus.br_ack, bus.br_taken} !== 2'b11)
            $display("FAIL fw_release ack/taken got=%b exp=11", {bus.br_ack, bus.br_taken}); else n_pass++;
        n_checks++;
        if (bus.hold_cnt !== 8'd1) $display("FAIL fw_hold_cnt got=%0d exp=1", bus.hold_cnt); else n_pass++;
        edge_step();
`endif
        apply(0, 0, 0, 4'd0, 3'b000, 0, 3'd0, 0);
        edge_step();
    endtask

    task automatic test_stall_hold();
        apply(1, 0, 0, 4'd0, 3'b000, 0, 3'd0, 0);
        edge_step();
        apply(0, 1, 0, 4'd0, 3'b001, 0, 3'd0, 0);
        edge_step();
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 1, 4'd0, 3'b000, 1, 3'd6, 0);
            n_checks++;
            if (bus.br_ack !== 1'b0) $display("FAIL stall_no_ack cyc=%0d got=%b exp=0", i, bus.br_ack); else n_pass++;
            edge_step();
        end
        apply(0, 0, 0, 4'd0, 3'b000, 1, 3'd6, 0);
        n_checks++;
        if ({bus.br_ack, bus.br_taken} !== 2'b11)
            $display("FAIL stall_release ack/taken got=%b exp=11", {bus.br_ack, bus.br_taken}); else n_pass++;
        n_checks++;
        if (bus.hold_cnt !== 8'd3) $display("FAIL stall_hold_cnt got=%0d exp=3", bus.hold_cnt); else n_pass++;
        edge_step();
        apply(0, 0, 0, 4'd0, 3'b000, 0, 3'd0, 0);
        edge_step();
    endtask

    task automatic test_flush();
        apply(1, 0, 0, 4'd0, 3'b000, 0, 3'd0, 0);
        edge_step();
        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 1, 4'd1, 3'b000, 1, 3'd0, 0);
            edge_step();
        end
        apply(0, 0, 0, 4'd0, 3'b000, 1, 3'd0, 1);
        n_checks++;
        if (bus.br_ack !== 1'b0) $display("FAIL flush_ack got=%b exp=0", bus.br_ack); else n_pass++;
        edge_step();
        apply(0, 1, 1, 4'd1, 3'b000, 1, 3'd7, 0);
        n_checks++;
        if ({bus.br_ack, bus.br_taken} !== 2'b11)
            $display("FAIL flush_uncond ack/taken got=%b exp=11", {bus.br_ack, bus.br_taken}); else n_pass++;
        edge_step();
        n_checks++;
        if (bus.hold_cnt !== 8'd2) $display("FAIL flush_hold got=%0d exp=2", bus.hold_cnt); else n_pass++;
        apply(0, 0, 0, 4'd0, 3'b000, 0, 3'd0, 0);
        edge_step();
    endtask

    task automatic test_saturation();
        apply(1, 0, 0, 4'd0, 3'b000, 0, 3'd0, 0);
        edge_step();
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 1, 4'd1, 3'b000, 1, 3'd0, 0);
            edge_step();
        end
        n_checks++;
        if (bus2.hold_cnt !== 2'd3) $display("FAIL sat_hold2 got=%0d exp=3", bus2.hold_cnt); else n_pass++;
        n_checks++;
        if (bus.hold_cnt !== 8'd5) $display("FAIL sat_hold8 got=%0d exp=5", bus.hold_cnt); else n_pass++;
        apply(0, 0, 0, 4'd0, 3'b000, 1, 3'd0, 0);
        n_checks++;
        if ({bus.br_ack, bus.br_taken} !== 2'b11)
            $display("FAIL sat_release ack/taken got=%b exp=11", {bus.br_ack, bus.br_taken}); else n_pass++;
        edge_step();
        apply(0, 0, 0, 4'd0, 3'b000, 0, 3'd0, 0);
        edge_step();
    endtask

    task automatic test_random();
        bit         req_on;
        logic [2:0] ccc_cur;
        logic       r;
        logic       fl;
        req_on  = 0;
        ccc_cur = 3'd0;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            fl = ($urandom_range(0, 19) == 0);
            if (!req_on) begin
                req_on  = $urandom_range(0, 1);
                ccc_cur = 3'($urandom_range(0, 7));
            end else if ($urandom_range(0, 9) == 0) begin
                req_on = 0;
            end
            apply(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), req_on, ccc_cur, fl);
            n_checks++;
            if (bus.br_ack !== e_ack) $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", i, bus.br_ack, e_ack); else n_pass++;
            if (e_ack) begin
                n_checks++;
                if (bus.br_taken !== e_taken)
                    $display("FAIL rnd_taken cyc=%0d ccc=%0d got=%b exp=%b", i, ccc_cur, bus.br_taken, e_taken);
                else n_pass++;
            end
            edge_step();
            if (e_ack || fl || r) req_on = 0;
            n_checks++;
            if ({bus.flag_Z, bus.flag_N, bus.flag_V} !== m_flags)
                $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, {bus.flag_Z, bus.flag_N, bus.flag_V}, m_flags);
            else n_pass++;
            n_checks++;
            if (int'(bus.hold_cnt) != m_hold || int'(bus2.hold_cnt) != m_hold2)
                $display("FAIL rnd_hold cyc=%0d got=%0d/%0d exp=%0d/%0d", i, bus.hold_cnt, bus2.hold_cnt, m_hold, m_hold2);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_flags  = 0;
        m_pend   = 0;
        m_hold   = 0;
        m_hold2  = 0;
        rst = 1'b1;
        bus.ex_valid = 0; bus.ex_stall = 0; bus.aluop = 4'd0;
        bus.Z = 0; bus.N = 0; bus.V = 0;
        bus.br_req = 0; bus.br_ccc = 3'd0; bus.flush = 0;
        test_reset();
        test_flag_mask();
        test_fw_branch();
        test_stall_hold();
        test_flush();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Holds the processor's architectural Z/N/V flag register, fed directly by the 16-bit ALU's Z, N and V outputs in the execute stage, and resolves conditional branches against those flags. It sits immediately downstream of the ALU. It applies the per-opcode flag-update mask and detects the flag read-after-write hazard between a branch and a flag-writing instruction still in EX. It resolves each branch through a req/ack handshake and counts branch hold cycles for performance monitoring.

## Interface
- HOLD_CNT_W, 8, width of the saturating branch-hold counter
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  an instruction occupies EX this cycle
- ex_stall  in  1  EX is stalled; its instruction does not commit flags this cycle
- aluop  in  4  opcode of the EX instruction, same encoding as ALU aluop
- Z, N, V  in  1 each  ALU flag outputs for the EX instruction
- br_req  in  1  branch in ID requests resolution; held high until br_ack
- br_ccc  in  3  branch condition code, stable while br_req high
- flush  in  1  cancel any pending branch request
- flag_Z, flag_N, flag_V  out  1 each  architectural flags (registered)
- br_ack  out  1  branch resolved this cycle (combinational)
- br_taken  out  1  condition result; valid only when br_ack=1
- hold_cnt  out  HOLD_CNT_W  saturating count of cycles spent in HOLD

## Operation
- Flag write mask, applied when ex_valid=1 and ex_stall=0:
  - aluop 0000 ADD and 0001 SUB update Z, N and V.
  - aluop 0010 XOR, 0100 SLL, 0101 SRA and 0110 ROR update Z only.
  - All other aluop values update no flags.
- A flag writer (fw) is an EX instruction with ex_valid=1 and a non-empty mask, regardless of ex_stall.
- Condition codes:
  - 000 NEQ: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GTE: Z=1 or N=0.
  - 101 LTE: Z=1 or N=1.
  - 110 OVFL: V=1.
  - 111 UNCOND: always taken.
- FSM states IDLE and HOLD:
  - IDLE, br_req=1, no fw: br_ack=1 this cycle, evaluated on the registered flags; stay in IDLE.
  - IDLE, br_req=1, fw present: behaviour per Configuration.
  - HOLD, fw still present (EX stalled): stay in HOLD, br_ack=0, hold_cnt increments.
  - HOLD, fw gone: br_ack=1, evaluated on the registered flags (already committed); go to IDLE.
- flush=1 has top priority for the branch path: br_ack=0, state goes to IDLE. Flag commit from EX is unaffected, since EX is older than the branch.
- br_req=0 in HOLD (upstream withdrew): go to IDLE, no ack.
- hold_cnt increments once per cycle spent in HOLD and saturates at all-ones.
- UNCOND never enters HOLD and is acked in IDLE the same cycle as the request.

## Timing
- Reset values: flag_Z=0, flag_N=0, flag_V=0, state IDLE, hold_cnt=0, br_ack=0, br_taken=0.
- Flag latency: the ALU flags committed at edge t appear on flag_* from cycle t+1.
- br_ack/br_taken are combinational from state, br_req, br_ccc, the flags and the EX inputs. No same-cycle dependence on br_ack exists inside the block.
- br_ack pulses for exactly one cycle per request. Upstream must deassert br_req, or present the next branch, in the cycle after ack.
- rst during HOLD returns to IDLE next cycle with no ack. rst takes priority over flush, and flush over ack.
- A back-to-back fw followed by a branch costs 1 hold cycle without the forwarding feature, plus 1 for each ex_stall cycle.

## Configuration
- FLAG_FWD_EN defined:
  - In IDLE with a fw present and ex_stall=0, the branch resolves the same cycle (br_ack=1).
  - It is evaluated on merged flags: each masked bit taken from the ALU Z/N/V, each unmasked bit from the registered flag.
  - If ex_stall=1, the block enters HOLD as normal.
- FLAG_FWD_EN undefined: any fw present with br_req enters HOLD, and hold_cnt counts that cycle.

## Test plan
- Reset, then br_req with ccc=001 and no fw → br_ack=1, br_taken=0; flags all 0; hold_cnt=0.
- ADD with ALU Z=1, N=0, V=1 committed, then XOR with Z=0, N=1, V=0 committed → flag_Z=0, flag_N=0, flag_V=1.
- SUB with Z=1 in EX plus br_req ccc=001 in the same cycle:
  - without FLAG_FWD_EN → no ack; next cycle br_ack=1, br_taken=1, hold_cnt=1.
  - with FLAG_FWD_EN → br_ack=1, br_taken=1 in the same cycle, hold_cnt=0.
- fw in EX with ex_stall=1 for 3 cycles plus br_req ccc=110 → HOLD for 3 cycles, then ack with br_taken equal to the committed V; hold_cnt=3.
- flush asserted in HOLD → br_ack never pulses; state IDLE; a new br_req ccc=111 → br_ack=1, br_taken=1 immediately.
- HOLD_CNT_W=2: force 5 hold cycles → hold_cnt saturates at 3.
